onchip_mem_scan_reader: RTL and testbench

//  Read-only streaming master for the 32-bit single-port on-chip RAM (13-bit word address, 5120 words).

---
 rtl/onchip_mem_scan_reader_pkg.sv | 15 +
 rtl/scan_sync_fifo.sv | 42 ++++
 rtl/onchip_mem_scan_reader.sv | 144 ++++++++++++++
 tb/tb_onchip_mem_scan_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_scan_reader_pkg.sv
// Shared definitions for the on-chip RAM scan reader: FSM encoding and default geometry.
package onchip_mem_scan_reader_pkg;

    localparam int DEF_ADDR_W      = 13;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_DEPTH_WORDS = 5120;
    localparam int DEF_FIFO_DEPTH  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is read straight from the register array.
module scan_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q[PW-1:0]] <= push_data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end

    assign empty_o     = (wr_q == rd_q);
    assign count_o     = wr_q - rd_q;
    assign head_data_o = mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/onchip_mem_scan_reader.sv
// Streams a block of consecutive on-chip RAM words into a ready/valid stream via a credit-limited FIFO.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_RUN   | issuing reads while FIFO credits remain
//   S_DRAIN | all reads issued, waiting for the last word to leave
module onchip_mem_scan_reader
    import onchip_mem_scan_reader_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);
    localparam int FPW = $clog2(FIFO_DEPTH);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;
    logic              inflight_q, last_tag_q, clken_q;

    logic [ADDR_W-1:0] len_clamped, base_wrapped, addr_next;
    logic [FPW:0]      fifo_count;
    logic [FPW+1:0]    occupancy;
    logic              fifo_empty, has_credit, issue, push, pop;
    logic [DATA_W:0]   head;

    assign len_clamped  = (length > ADDR_W'(DEPTH_WORDS)) ? ADDR_W'(DEPTH_WORDS) : length;
    assign base_wrapped = (base_addr >= ADDR_W'(DEPTH_WORDS)) ? base_addr - ADDR_W'(DEPTH_WORDS)
                                                              : base_addr;
    assign addr_next    = (addr_q == ADDR_W'(DEPTH_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);

    // A slot is reserved for the read in flight so a returning word always fits.
    assign occupancy  = {1'b0, fifo_count} + (FPW+2)'(inflight_q);
    assign has_credit = occupancy < (FPW+2)'(FIFO_DEPTH);
    assign issue      = (state_q == S_RUN) && (rem_q != '0) && has_credit && !abort;
    assign push       = inflight_q && !abort;
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        addr_d  = base_wrapped;
                        rem_d   = len_clamped;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_next;
                    rem_d  = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head[DATA_W]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            rem_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            last_tag_q <= 1'b0;
            clken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            inflight_q <= issue;
            last_tag_q <= issue && (rem_q == ADDR_W'(1));
            clken_q    <= 1'b1;
        end
    end

    scan_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (abort),
        .push_i      (push),
        .push_data_i ({last_tag_q, mem_readdata}),
        .pop_i       (pop),
        .head_data_o (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = clken_q;
    assign out_valid      = !fifo_empty;
    assign out_data       = head[DATA_W-1:0];
    assign out_last       = head[DATA_W] && out_valid;

endmodule

// File: tb/tb_onchip_mem_scan_reader.sv
// Scoreboard bench for onchip_mem_scan_reader with a behavioural 1-cycle-latency RAM.
module tb_onchip_mem_scan_reader;
    localparam int DEPTH = 5120;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [12:0] base_addr = '0, length = '0;
    logic        busy, done, mem_chipselect, mem_write, mem_clken, out_valid, out_last;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = '0, out_data;

    logic [31:0] ram [DEPTH];
    logic [32:0] sb_q [$];
    int vectors = 0, miscompares = 0;
    int iss_cnt = 0, pop_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    onchip_mem_scan_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    always @(posedge clk)
        if (mem_chipselect && mem_clken) mem_readdata <= ram[mem_address];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_chipselect) iss_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (sb_q.size() == 0) chk("sb_unexpected", 1, 0);
                else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("sb_data", out_data, e[31:0]);
                    chk("sb_last", out_last, e[32]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a 1-cycle start and returns in cycle T1.
    task automatic launch(input int base, input int len);
        int n, b;
        n = (len > DEPTH) ? DEPTH : len;
        b = base % DEPTH;
        for (int k = 0; k < n; k++) sb_q.push_back({(k == n - 1), ram[(b + k) % DEPTH]});
        start = 1'b1; base_addr = 13'(base); length = 13'(len);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int first_k, input int max, output int n);
        n = -1;
        for (int k = first_k; k <= max; k++) begin
            if (done === 1'b1) begin
                n = k;
                break;
            end
            step();
        end
        if (n < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'hC0DE_0000 | i;
        for (int i = 0; i < 4; i++) ram[16 + i] = 32'hA0 + i;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_clken", mem_clken, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        reset_n = 1'b1;
        step(); step();
        chk("clken_on", mem_clken, 1);
        chk("mem_write", mem_write, 0);
        chk("mem_be", mem_byteenable, 4'hF);

        // 1: basic 4-word scan, latency and done timing
        launch(16, 4);
        chk("t1_cs", mem_chipselect, 1);
        chk("t1_addr", mem_address, 16);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_valid_T2", out_valid, 0);
        step();
        chk("t1_valid_T3", out_valid, 1);
        chk("t1_data_T3", out_data, 32'hA0);
        wait_done(3, 50, n);
        chk("t1_done_T", n, 7);
        chk("t1_busy_done", busy, 0);
        step();
        chk("t1_done_once", done, 0);
        chk("t1_sb_empty", sb_q.size(), 0);

        // 2: address wrap at the top of RAM
        launch(5118, 4);
        chk("t2_a0", mem_address, 5118);
        step(); chk("t2_a1", mem_address, 5119);
        step(); chk("t2_a2", mem_address, 0);
        step(); chk("t2_a3", mem_address, 1);
        chk("t2_cs3", mem_chipselect, 1);
        wait_done(4, 50, n);
        chk("t2_done_T", n, 7);
        step();
        chk("t2_sb_empty", sb_q.size(), 0);

        // 3: consumer stall fills the FIFO, reads throttle
        iss_cnt = 0; pop_cnt = 0;
        launch(512, 20);
        step(); step(); step();
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("t3_cs_stalled", mem_chipselect, 0);
        chk("t3_outstanding", iss_cnt - pop_cnt, 8);
        chk("t3_valid", out_valid, 1);
        chk("t3_head", out_data, sb_q[0][31:0]);
        step();
        out_ready = 1'b1;
        wait_done(16, 300, n);
        step();
        chk("t3_sb_empty", sb_q.size(), 0);
        chk("t3_issued", iss_cnt, 20);

        // 4: zero-length start
        d0 = done_cnt;
        launch(80, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 1);
        chk("t4_cs", mem_chipselect, 0);
        step();
        chk("t4_done_off", done, 0);
        chk("t4_valid", out_valid, 0);
        chk("t4_done_cnt", done_cnt - d0, 1);

        // 5: abort mid-scan while a read returns, then restart
        launch(768, 16);
        step(); step(); step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        sb_q.delete();
        d0 = done_cnt;
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        for (int i = 0; i < 5; i++) step();
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_idle_valid", out_valid, 0);
        launch(256, 2);
        wait_done(1, 50, n);
        chk("t5_done_T", n, 5);
        step();
        chk("t5_sb_empty", sb_q.size(), 0);

        // base beyond RAM depth and oversize length
        launch(5125, 2);
        chk("wrap_base", mem_address, 5);
        wait_done(1, 50, n);
        step();
        iss_cnt = 0;
        launch(100, 8191);
        wait_done(1, 6000, n);
        chk("clamp_done_T", n, 5123);
        step();
        chk("clamp_issued", iss_cnt, 5120);
        chk("clamp_sb_empty", sb_q.size(), 0);

        // 6: async reset mid-scan
        launch(1024, 10);
        step(); step();
        #3 reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_cs", mem_chipselect, 0);
        chk("t6_clken", mem_clken, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_last", out_last, 0);
        chk("t6_addr", mem_address, 0);
        chk("t6_data", out_data, 0);
        sb_q.delete();
        #2 reset_n = 1'b1;
        step();
        chk("t6_clken_on", mem_clken, 1);
        chk("t6_idle", busy, 0);
        launch(32, 3);
        chk("t6_restart_addr", mem_address, 32);
        wait_done(1, 50, n);
        chk("t6_done_T", n, 6);
        step();
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
